// File: rtl/phase_sequencer_if.sv
// Phase sequencer control/status bundle.
// master: the controller that drives run/stall/end_instr/halt and observes step status.
// slave: the sequencer that produces the step strobes.
interface phase_sequencer_if #(
    parameter int unsigned NUM_STEPS = 8
);
    localparam int unsigned IDX_W = $clog2(NUM_STEPS);

    logic                 run;
    logic                 stall;
    logic                 end_instr;
    logic                 halt;
    logic [NUM_STEPS-1:0] step;
    logic [IDX_W-1:0]     step_idx;
    logic                 fetch;
    logic                 busy;
    logic                 instr_done;
    logic                 halted;
    logic [31:0]          instr_count;

    modport master (
        output run, stall, end_instr, halt,
        input  step, step_idx, fetch, busy, instr_done, halted, instr_count
    );

    modport slave (
        input  run, stall, end_instr, halt,
        output step, step_idx, fetch, busy, instr_done, halted, instr_count
    );
endinterface

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: walks one-hot control steps T0..T(NUM_STEPS-1),
// with stall, early end outside the fetch phase, and halt at instruction boundaries.
// Optional feature macro: SEQ_INSTR_COUNT_EN builds the retired-instruction counter;
// when undefined instr_count is tied to zero.
module phase_sequencer #(
    parameter int unsigned NUM_STEPS   = 8,
    parameter int unsigned FETCH_STEPS = 3
) (
    input  logic             clk,
    input  logic             clr,
    phase_sequencer_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     step_idx_q, step_idx_d;
    logic [NUM_STEPS-1:0] step_q, step_d;
    logic                 fetch_q, fetch_d;
    logic                 busy_q, busy_d;
    logic                 halted_q, halted_d;
    logic                 instr_done_q, instr_done_d;
    logic                 boundary_c;

    // Next-state and next-output decode; all outputs derive from the next state.
    always_comb begin
        state_d      = state_q;
        step_idx_d   = step_idx_q;
        instr_done_d = 1'b0;
        boundary_c   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run) begin
                    state_d    = ST_RUN;
                    step_idx_d = '0;
                end
            end
            ST_RUN: begin
                if (!bus.stall) begin
                    boundary_c = (step_idx_q == IDX_W'(NUM_STEPS - 1)) ||
                                 (bus.end_instr && (step_idx_q >= IDX_W'(FETCH_STEPS)));
                    if (boundary_c) begin
                        instr_done_d = 1'b1;
                        step_idx_d   = '0;
                        if (bus.halt) begin
                            state_d = ST_HALTED;
                        end else if (!bus.run) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        step_idx_d = step_idx_q + IDX_W'(1);
                    end
                end
            end
            ST_HALTED: begin
                state_d    = ST_HALTED;
                step_idx_d = '0;
            end
            default: begin
                state_d    = ST_IDLE;
                step_idx_d = '0;
            end
        endcase

        busy_d   = (state_d == ST_RUN);
        halted_d = (state_d == ST_HALTED);
        step_d   = busy_d ? (NUM_STEPS'(1) << step_idx_d) : '0;
        fetch_d  = busy_d && (step_idx_d < IDX_W'(FETCH_STEPS));
    end

    // State and registered output flops.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= ST_IDLE;
            step_idx_q   <= '0;
            step_q       <= '0;
            fetch_q      <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            instr_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_idx_q   <= step_idx_d;
            step_q       <= step_d;
            fetch_q      <= fetch_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
            instr_done_q <= instr_done_d;
        end
    end

`ifdef SEQ_INSTR_COUNT_EN
    logic [31:0] instr_count_q, instr_count_d;

    // Retired-instruction counter, bumps on every boundary edge and wraps naturally.
    always_comb begin
        instr_count_d = instr_count_q;
        if (instr_done_d) begin
            instr_count_d = instr_count_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            instr_count_q <= '0;
        end else begin
            instr_count_q <= instr_count_d;
        end
    end

    assign bus.instr_count = instr_count_q;
`else
    assign bus.instr_count = 32'd0;
`endif

    assign bus.step       = step_q;
    assign bus.step_idx   = step_idx_q;
    assign bus.fetch      = fetch_q;
    assign bus.busy       = busy_q;
    assign bus.halted     = halted_q;
    assign bus.instr_done = instr_done_q;
endmodule
